// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the ALU operation sequencer.
//   CMD_W / *_LSB / *_BIT : layout of the 22-bit queued command word
//                           {chain, sel[3:0], cin, b[7:0], a[7:0]}
//   alu_seq_state_e       : sequencer FSM state encoding
//   DEFAULT_DEPTH         : default command FIFO depth
// Optional feature macro used by the sequencer: ALU_SEQ_CARRY_CHAIN_EN
package alu_seq_pkg;

   localparam int CMD_W         = 22;
   localparam int A_LSB         = 0;
   localparam int B_LSB         = 8;
   localparam int CIN_BIT       = 16;
   localparam int SEL_LSB       = 17;
   localparam int CHAIN_BIT     = 21;
   localparam int DEFAULT_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      HOLD  = 2'd2
   } alu_seq_state_e;

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo -- synchronous command FIFO for the ALU sequencer.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write request and data; ignored while full
//   pop/rdata  : read request; rdata always shows the head entry
//   full/empty : occupancy flags
//   count      : number of stored entries (0..DEPTH)
module alu_seq_fifo
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int W     = CMD_W,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read behind the count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer -- queues ALU commands and sequences them one at a time
// through an external combinational ALU, presenting each result on a
// valid/ready output.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_a/b/cin/sel/chain : command input
//   alu_a/b/cin/s (registered)       : operands driven to the ALU
//   alu_d/z/cout                     : ALU results
//   res_valid/res_ready, res_d/z/cout: result output
//   busy                             : FSM not IDLE or commands queued
//   fsm_state, fifo_count            : debug visibility of FSM and FIFO
// Handshakes (cmd_*, res_*): a transfer happens on a rising edge where valid
// and ready are both high; the source holds valid and data until then.
// Macro ALU_SEQ_CARRY_CHAIN_EN: when defined, a command with cmd_chain set
// uses the carry-out of the previous operation as its carry-in.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [7:0]     cmd_a,
   input  logic [7:0]     cmd_b,
   input  logic           cmd_cin,
   input  logic [3:0]     cmd_sel,
   input  logic           cmd_chain,
   output logic [7:0]     alu_a,
   output logic [7:0]     alu_b,
   output logic           alu_cin,
   output logic [3:0]     alu_s,
   input  logic [7:0]     alu_d,
   input  logic           alu_z,
   input  logic           alu_cout,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [7:0]     res_d,
   output logic           res_z,
   output logic           res_cout,
   output logic           busy,
   output alu_seq_state_e fsm_state,
   output logic [CW-1:0]  fifo_count
);

   logic [CMD_W-1:0] cmd_word;
   logic [CMD_W-1:0] head;
   logic             full;
   logic             empty;
   logic             pop;
   logic             next_cin;

   assign cmd_word = {cmd_chain, cmd_sel, cmd_cin, cmd_b, cmd_a};

   alu_seq_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .wdata (cmd_word),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign cmd_ready = !full;
   assign busy      = (fsm_state != IDLE) || !empty;

   // A new command is issued from IDLE, or straight out of HOLD when the
   // current result is accepted, which gives one result every two cycles.
   assign pop = !empty && ((fsm_state == IDLE) ||
                           ((fsm_state == HOLD) && res_ready));

`ifdef ALU_SEQ_CARRY_CHAIN_EN
   logic last_cout;
   assign next_cin = head[CHAIN_BIT] ? last_cout : head[CIN_BIT];
`else
   logic unused_chain;
   assign unused_chain = ^{cmd_chain, head[CHAIN_BIT]};
   assign next_cin     = head[CIN_BIT];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_state <= IDLE;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_cin   <= 1'b0;
         alu_s     <= '0;
         res_valid <= 1'b0;
         res_d     <= '0;
         res_z     <= 1'b0;
         res_cout  <= 1'b0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
         last_cout <= 1'b0;
`endif
      end else begin
         case (fsm_state)
            IDLE: begin
               if (!empty) fsm_state <= DRIVE;
            end
            // One settling cycle for the ALU, then capture its outputs.
            DRIVE: begin
               res_d     <= alu_d;
               res_z     <= alu_z;
               res_cout  <= alu_cout;
               res_valid <= 1'b1;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
               last_cout <= alu_cout;
`endif
               fsm_state <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  fsm_state <= empty ? IDLE : DRIVE;
               end
            end
            default: fsm_state <= IDLE;
         endcase
         // Operand registers change only on issue, so they hold the last
         // issued command through HOLD and IDLE.
         if (pop) begin
            alu_a   <= head[A_LSB +: 8];
            alu_b   <= head[B_LSB +: 8];
            alu_s   <= head[SEL_LSB +: 4];
            alu_cin <= next_cin;
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer -- self-checking bench for alu_op_sequencer with a
// behavioural ALU and an in-order expected-result queue.
// Honours ALU_SEQ_CARRY_CHAIN_EN when compiled with it.
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int EW    = 31; // {cin_eff, sel[3:0], a[7:0], b[7:0], cout, z, d[7:0]}

   logic           clk;
   logic           rst_n;
   logic           cmd_valid;
   logic           cmd_ready;
   logic [7:0]     cmd_a;
   logic [7:0]     cmd_b;
   logic           cmd_cin;
   logic [3:0]     cmd_sel;
   logic           cmd_chain;
   logic [7:0]     alu_a;
   logic [7:0]     alu_b;
   logic           alu_cin;
   logic [3:0]     alu_s;
   logic [7:0]     alu_d;
   logic           alu_z;
   logic           alu_cout;
   logic           res_valid;
   logic           res_ready;
   logic [7:0]     res_d;
   logic           res_z;
   logic           res_cout;
   logic           busy;
   alu_seq_state_e fsm_state;
   logic [CW-1:0]  fifo_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int n_acc  = 0;
   logic rand_mode = 1'b0;

   logic [EW-1:0] exp_q[$];
   int            hs_times[$];
   logic          m_last_cout = 1'b0;
   logic          have_last   = 1'b0;
   logic [EW-1:0] last_entry  = '0;

   alu_op_sequencer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_cin    (cmd_cin),
      .cmd_sel    (cmd_sel),
      .cmd_chain  (cmd_chain),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cin    (alu_cin),
      .alu_s      (alu_s),
      .alu_d      (alu_d),
      .alu_z      (alu_z),
      .alu_cout   (alu_cout),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_d      (res_d),
      .res_z      (res_z),
      .res_cout   (res_cout),
      .busy       (busy),
      .fsm_state  (fsm_state),
      .fifo_count (fifo_count)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference ALU ----------------
   // sel 0: {cout,d} = a+b+cin; any other sel: d = a^b, cout = 0.
   function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic [3:0] sel);
      int         s;
      logic [7:0] d;
      logic       c;
      if (sel == 4'd0) begin
         s = int'(a) + int'(b) + int'(cin);
         d = 8'(s);
         c = (s > 255);
      end else begin
         d = a ^ b;
         c = 1'b0;
      end
      return {c, (d == 8'd0), d};
   endfunction

   always_comb begin
      {alu_cout, alu_z, alu_d} = alu_ref(alu_a, alu_b, alu_cin, alu_s);
   end

   // ---------------- check helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   // ---------------- scoreboard / compare process ----------------
   always @(negedge clk) begin : mon
      logic [EW-1:0] e;
      logic [9:0]    r;
      logic          cin_eff;
      if (rst_n) begin
         // Outstanding = queued + in flight; capacity is DEPTH + 1.
         chk("cmd_ready", 32'(cmd_ready), 32'(exp_q.size() <= DEPTH));
         chk("busy", 32'(busy), 32'(exp_q.size() != 0));
         chk("fifo_count_max", 32'(fifo_count <= CW'(DEPTH)), 32'd1);
         if (res_valid) begin
            if (exp_q.size() == 0) begin
               fail_timeout("res_spurious");
            end else begin
               e = exp_q[0];
               chk("res_d", 32'(res_d), 32'(e[7:0]));
               chk("res_z", 32'(res_z), 32'(e[8]));
               chk("res_cout", 32'(res_cout), 32'(e[9]));
               chk("hold_alu_ops", 32'({alu_s, alu_a, alu_b, alu_cin}),
                   32'({e[29:26], e[25:18], e[17:10], e[30]}));
               if (res_ready) begin
                  void'(exp_q.pop_front());
                  hs_times.push_back(cyc);
               end
            end
         end else if (exp_q.size() == 0) begin
            // Idle: operand registers keep the last issued command (0 after reset).
            e = have_last ? last_entry : '0;
            chk("idle_alu_ops", 32'({alu_s, alu_a, alu_b, alu_cin}),
                32'({e[29:26], e[25:18], e[17:10], e[30]}));
         end
         if (cmd_valid && cmd_ready) begin
`ifdef ALU_SEQ_CARRY_CHAIN_EN
            cin_eff = cmd_chain ? m_last_cout : cmd_cin;
`else
            cin_eff = cmd_cin;
`endif
            r           = alu_ref(cmd_a, cmd_b, cin_eff, cmd_sel);
            m_last_cout = r[9];
            e           = {cin_eff, cmd_sel, cmd_a, cmd_b, r};
            exp_q.push_back(e);
            last_entry  = e;
            have_last   = 1'b1;
            n_acc++;
         end
      end
   end

   // Random backpressure during the random phase.
   always @(posedge clk) begin
      if (rand_mode) begin
         #1 res_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- driver tasks (called at posedge + 1) ----------------
   task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic [3:0] sel, input logic chain);
      int t = 0;
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_cin   = cin;
      cmd_sel   = sel;
      cmd_chain = chain;
      @(negedge clk);
      while (!cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) fail_timeout("push_wait");
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic get_result(output logic [7:0] d, output logic z, output logic c);
      int t = 0;
      res_ready = 1'b1;
      @(negedge clk);
      while (!res_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!res_valid) fail_timeout("result_wait");
      d = res_d;
      z = res_z;
      c = res_cout;
      @(posedge clk);
      #1 res_ready = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (busy && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (busy) fail_timeout("idle_wait");
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_res"}, 32'({res_d, res_z, res_cout}), 32'd0);
      chk({tag, "_alu"}, 32'({alu_a, alu_b, alu_cin, alu_s}), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_count"}, 32'(fifo_count), 32'd0);
      chk({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_last_cout = 1'b0;
      have_last   = 1'b0;
      last_entry  = '0;
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      logic [7:0] d;
      logic       z;
      logic       c;
      int         base;

      rst_n     = 1'b1;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_cin   = 1'b0;
      cmd_sel   = '0;
      cmd_chain = 1'b0;
      res_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("rst_init");
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single op latency: push at edge N, res_valid only after N+2.
      cmd_valid = 1'b1; cmd_a = 8'h03; cmd_b = 8'h04; cmd_cin = 1'b1;
      cmd_sel = 4'd0; cmd_chain = 1'b0;
      @(posedge clk);            // edge N
      #1 cmd_valid = 1'b0;
      @(posedge clk);            // edge N+1
      @(negedge clk);
      chk("lat_n1_valid", 32'(res_valid), 32'd0);
      @(posedge clk);            // edge N+2
      @(negedge clk);
      chk("lat_n2_valid", 32'(res_valid), 32'd1);
      chk("single_d", 32'(res_d), 32'h08);
      chk("single_z", 32'(res_z), 32'd0);
      chk("single_cout", 32'(res_cout), 32'd0);
      @(posedge clk);
      #1 get_result(d, z, c);
      wait_idle();

      // Backpressure: 5 accepted, 6th waits for the first result handshake.
      base = n_acc;
      for (int i = 0; i < 5; i++)
         push_cmd(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 4'd0, 1'b0);
      cmd_valid = 1'b1; cmd_a = 8'h10; cmd_b = 8'h20; cmd_cin = 1'b0;
      cmd_sel = 4'd0; cmd_chain = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("bp_ready_low", 32'(cmd_ready), 32'd0);
      end
      chk("bp_accepted5", 32'(n_acc - base), 32'd5);
      @(posedge clk);
      #1 res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      chk("bp_ready_after", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      chk("bp_accepted6", 32'(n_acc - base), 32'd6);
      res_ready = 1'b1;
      wait_idle();
      res_ready = 1'b0;

      // Carry chain.
      push_cmd(8'hFF, 8'h01, 1'b0, 4'd0, 1'b0);
      get_result(d, z, c);
      chk("chain1_d", 32'(d), 32'h00);
      chk("chain1_z", 32'(z), 32'd1);
      chk("chain1_cout", 32'(c), 32'd1);
      push_cmd(8'h00, 8'h00, 1'b0, 4'd0, 1'b1);
      get_result(d, z, c);
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      chk("chain2_d", 32'(d), 32'h01);
      chk("chain2_z", 32'(z), 32'd0);
`else
      chk("chain2_d", 32'(d), 32'h00);
      chk("chain2_z", 32'(z), 32'd1);
`endif
      chk("chain2_cout", 32'(c), 32'd0);
      wait_idle();

      // Reset mid-operation: one in HOLD, three queued.
      for (int i = 0; i < 4; i++)
         push_cmd(8'($urandom), 8'($urandom), 1'b0, 4'd0, 1'b0);
      @(negedge clk);
      chk("pre_rst_hold", 32'(res_valid), 32'd1);
      chk("pre_rst_count", 32'(fifo_count), 32'd3);
      @(posedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_reset_outputs("rst_mid");
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 push_cmd(8'h01, 8'h01, 1'b0, 4'd0, 1'b0);
      get_result(d, z, c);
      chk("post_rst_d", 32'(d), 32'h02);
      repeat (6) begin
         @(negedge clk);
         chk("post_rst_no_stale", 32'(res_valid), 32'd0);
      end
      @(posedge clk);
      #1;

      // Streaming: 8 back-to-back with res_ready high -> 2-cycle spacing.
      res_ready = 1'b1;
      hs_times.delete();
      for (int i = 0; i < 8; i++)
         push_cmd(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 4'd0,
                  1'($urandom_range(0, 1)));
      wait_idle();
      chk("stream_results", 32'(hs_times.size()), 32'd8);
      for (int i = 1; i < hs_times.size(); i++)
         chk("stream_spacing", 32'(hs_times[i] - hs_times[i-1]), 32'd2);
      res_ready = 1'b0;

      // Random phase: random operands, selects, chaining, gaps, backpressure.
      rand_mode = 1'b1;
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         push_cmd(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                  1'($urandom_range(0, 1)));
      end
      rand_mode = 1'b0;
      @(posedge clk);
      #2 res_ready = 1'b1;
      wait_idle();
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      errors++;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command FIFO can accept.
REQ-006 SHALL have ports cmd_a, cmd_b  input  8 each  operands.
REQ-007 SHALL have port cmd_cin  input  1  carry-in for the op.
REQ-008 SHALL have port cmd_sel  input  4  ALU select code, passed through unmodified.
REQ-009 SHALL have port cmd_chain  input  1  use previous carry-out as carry-in.
REQ-010 SHALL have ports alu_a, alu_b  output  8 each; alu_cin  output  1; alu_s  output  4; all registered, driven to the downstream combinational ALU.
REQ-011 SHALL have ports alu_d  input  8; alu_z  input  1; alu_cout  input  1; ALU results.
REQ-012 SHALL have port res_valid  output  1; res_ready  input  1; res_d  output  8; res_z  output  1; res_cout  output  1.
REQ-013 SHALL have port busy  output  1, high when the state is not IDLE or the FIFO is non-empty.

Function
REQ-014 SHALL push a command when cmd_valid and cmd_ready are both high; cmd_ready SHALL equal !full.
REQ-015 SHALL ignore cmd_valid while full; push and pop in the same cycle SHALL be legal at any occupancy, count unchanged.
REQ-016 SHALL implement FSM states IDLE, DRIVE, HOLD.
REQ-017 IDLE: FIFO non-empty -> pop, load alu_* registers, go DRIVE; else stay.
REQ-018 DRIVE: exactly one cycle of ALU settling; on exit edge capture alu_d/alu_z/alu_cout into res_* registers, set res_valid, go HOLD.
REQ-019 HOLD: res_* and alu_* stable while res_valid && !res_ready.
REQ-020 HOLD: on res_ready, clear res_valid; if FIFO non-empty pop and go DRIVE on the same edge, else go IDLE.
REQ-021 Latency: command pushed into an empty FIFO at edge N while in IDLE SHALL produce res_valid high after edge N+2.
REQ-022 Throughput with res_ready held high SHALL be one result per 2 cycles.
REQ-023 Total in-flight capacity SHALL be DEPTH queued plus one in DRIVE/HOLD.
REQ-024 alu_* registers SHALL retain the last issued command while in IDLE.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, FIFO empty, and res_valid, res_d, res_z, res_cout, alu_a, alu_b, alu_cin, alu_s and busy to 0.
REQ-026 cmd_ready SHALL be 1 during reset.
REQ-027 Reset mid-operation SHALL discard all queued and in-flight commands with no partial result emitted.

Configuration
REQ-028 Macro ALU_SEQ_CARRY_CHAIN_EN defined: alu_cin = cmd_chain ? last_cout : cmd_cin.
REQ-029 last_cout SHALL be a register, reset 0, updated with alu_cout at every DRIVE exit.
REQ-030 Macro undefined: cmd_chain SHALL be ignored, alu_cin = cmd_cin, and no last_cout register SHALL exist.

Structure
REQ-031 Package alu_seq_pkg SHALL hold the command word width (22 bits: a, b, cin, sel, chain), field offsets, FSM state encoding and the default DEPTH.
REQ-032 FIFO SHALL be sub-module alu_seq_fifo (synchronous, same clk/rst_n, full/empty/count).

Verification
REQ-033 Bench SHALL model the ALU with S=0000 computing {Cout,D} = A+B+Cin and Z = (D==0).
REQ-034 Reset: pulse rst_n low mid-cycle -> all outputs 0 immediately; cmd_ready=1.
REQ-035 Single op: A=03, B=04, Cin=1, S=0000 pushed at edge N -> res_valid after N+2; res_d=08, res_z=0, res_cout=0.
REQ-036 Backpressure: res_ready=0, DEPTH=4, offer 6 commands -> 5 accepted, cmd_ready=0 on the 6th until the first res handshake; results in order.
REQ-037 Chain (macro on): FF+01, Cin=0 -> D=00, Z=1, Cout=1; then 00+00, chain=1 -> D=01, Cout=0. Macro off: same second op with cmd_cin=0 -> D=00, Z=1.
REQ-038 Reset mid-operation in HOLD with 3 queued -> res_valid=0, busy=0; the next pushed A=01, B=01 returns D=02 only.
REQ-039 Streaming: 8 back-to-back ops with res_ready=1 -> results at 2-cycle spacing, count never exceeds DEPTH.
